// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - operand/result handshake bundle for the bit-serial adder
// SERIAL_ADDER_SUB_EN adds the sub strobe alongside the operands.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output in_valid, a, b, c_in, sub, out_ready,
                    input  in_ready, out_valid, sum, c_out, busy);
    modport slave  (input  in_valid, a, b, c_in, sub, out_ready,
                    output in_ready, out_valid, sum, c_out, busy);
`else
    modport master (output in_valid, a, b, c_in, out_ready,
                    input  in_ready, out_valid, sum, c_out, busy);
    modport slave  (input  in_valid, a, b, c_in, out_ready,
                    output in_ready, out_valid, sum, c_out, busy);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer, one full-adder cell, LSB first
// SERIAL_ADDER_SUB_EN enables subtraction (B inverted, carry-in flipped).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             carry;
    logic             fa_sum;
    logic             fa_cout;
    logic             sub_bit;
    logic             last_bit;
    logic             in_ready;
    logic             out_valid;
    logic             busy;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_bit = bus.sub;
`else
    assign sub_bit = 1'b0;
`endif

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_sum),
        .co (fa_cout)
    );

    // res_sr keeps only the WIDTH-1 bits already produced; the newest bit enters at the top
    assign res_next = {fa_sum, res_sr};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry   <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b ^ {WIDTH{sub_bit}};
                        carry <= bus.c_in ^ sub_bit;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res_sr <= res_next[WIDTH-1:1];
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_cout;
                    if (last_bit) begin
                        cnt     <= '0;
                        sum_q   <= res_next;
                        c_out_q <= fa_cout;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
endmodule
